mul_hilo_ctrl: RTL

//  Sequencer for the shared 32x32 unsigned array multiplier in the MIPS EX stage.

---
 rtl/mul_hilo_ctrl_if.sv | 37 +++
 rtl/mul_hilo_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mul_hilo_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mul_hilo_ctrl_if
//  Description : Decoder <-> HI/LO multiply sequencer bus. The decoder side
//                (master) issues operations and observes busy/done and the
//                architectural HI/LO values; the sequencer is the slave.
//  Signals     : start  issue strobe
//                op     3-bit operation code
//                a, b   rs / rt operands (32 bits each)
//                flush  pipeline kill
//                busy   multiply in flight
//                done   one-cycle pulse with the HI/LO update
//                hi, lo architectural HI / LO registers
//  Revision    : 1.0  initial release
// ============================================================================
interface mul_hilo_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/mul_hilo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mul_hilo_ctrl
//  Description : Sequencer for the shared 32x32 unsigned array multiplier in
//                the EX stage. Loads operand magnitudes, holds them for
//                MUL_CYCLES cycles (multicycle path), captures the product,
//                applies sign correction and writes HI/LO. MTHI/MTLO write
//                HI/LO directly in a single cycle.
//  Parameters  : MUL_CYCLES  operand hold cycles before capture (1..15)
//  Ports       : clk         clock, rising edge
//                rst         asynchronous active-high reset
//                bus         decoder bus (slave modport): start, op, a, b,
//                            flush in; busy, done, hi, lo out
//                mul_a/mul_b registered operands to the array multiplier
//                mul_result  64-bit unsigned product from the multiplier
//  Options     : MUL_HILO_MADD_EN  enables MADDU/MADD (op 100/101) which
//                accumulate the product into {hi,lo}
//  Revision    : 1.0  initial release
// ============================================================================
module mul_hilo_ctrl #(
    parameter int MUL_CYCLES = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    mul_hilo_ctrl_if.slave   bus,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    input  wire logic [63:0] mul_result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    localparam logic [2:0] C_OP_MULTU = 3'b000;
    localparam logic [2:0] C_OP_MULT  = 3'b001;
    localparam logic [2:0] C_OP_MTHI  = 3'b010;
    localparam logic [2:0] C_OP_MTLO  = 3'b011;
`ifdef MUL_HILO_MADD_EN
    localparam logic [2:0] C_OP_MADDU = 3'b100;
    localparam logic [2:0] C_OP_MADD  = 3'b101;
`endif
    localparam logic [3:0] C_CNT_LOAD = 4'(MUL_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_neg;
    logic [63:0] r_prod;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_mul_a;
    logic [31:0] r_mul_b;
    logic        r_busy;
    logic        r_done;
`ifdef MUL_HILO_MADD_EN
    logic        r_acc;
    logic        w_acc;
`endif

    logic        w_issue;
    logic        w_signed;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [63:0] w_res;
    logic [63:0] w_wb;

    // Operation decode: which ops start a multiply and whether signed.
    always_comb begin
        w_issue  = 1'b0;
        w_signed = 1'b0;
`ifdef MUL_HILO_MADD_EN
        w_acc    = 1'b0;
`endif
        case (bus.op)
            C_OP_MULTU: w_issue = 1'b1;
            C_OP_MULT: begin
                w_issue  = 1'b1;
                w_signed = 1'b1;
            end
`ifdef MUL_HILO_MADD_EN
            C_OP_MADDU: begin
                w_issue = 1'b1;
                w_acc   = 1'b1;
            end
            C_OP_MADD: begin
                w_issue  = 1'b1;
                w_signed = 1'b1;
                w_acc    = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Two's-complement magnitude; 0x80000000 maps onto itself, which is the
    // correct unsigned magnitude of -2^31.
    assign w_abs_a = bus.a[31] ? (~bus.a + 32'd1) : bus.a;
    assign w_abs_b = bus.b[31] ? (~bus.b + 32'd1) : bus.b;

    assign w_res = r_neg ? (~r_prod + 64'd1) : r_prod;
`ifdef MUL_HILO_MADD_EN
    assign w_wb  = r_acc ? ({r_hi, r_lo} + w_res) : w_res;
`else
    assign w_wb  = w_res;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_neg   <= 1'b0;
            r_prod  <= 64'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_mul_a <= 32'd0;
            r_mul_b <= 32'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef MUL_HILO_MADD_EN
            r_acc   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // flush in IDLE suppresses every same-cycle issue,
                    // including the single-cycle HI/LO moves.
                    if (bus.start && !bus.flush) begin
                        if (w_issue) begin
                            r_mul_a <= w_signed ? w_abs_a : bus.a;
                            r_mul_b <= w_signed ? w_abs_b : bus.b;
                            r_neg   <= w_signed & (bus.a[31] ^ bus.b[31]);
                            r_cnt   <= C_CNT_LOAD;
                            r_state <= S_CALC;
                            r_busy  <= 1'b1;
`ifdef MUL_HILO_MADD_EN
                            r_acc   <= w_acc;
`endif
                        end else if (bus.op == C_OP_MTHI) begin
                            r_hi <= bus.a;
                        end else if (bus.op == C_OP_MTLO) begin
                            r_lo <= bus.a;
                        end
                    end
                end
                S_CALC: begin
                    if (bus.flush) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == 4'd0) begin
                        r_prod  <= mul_result;
                        r_state <= S_WB;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_WB: begin
                    // A kill arriving in WB still wins over the write.
                    if (!bus.flush) begin
                        {r_hi, r_lo} <= w_wb;
                        r_done       <= 1'b1;
                    end
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign mul_a    = r_mul_a;
    assign mul_b    = r_mul_b;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule
`default_nettype wire
